// File: rtl/evr_rx_decoder_if.sv
// evr_rx_decoder_if: receive word in, decoded event/timing status out; master = transceiver/application side, slave = decoder
interface evr_rx_decoder_if #(
  parameter int TOD_SECONDS_WIDTH = 32
);
  logic [15:0] evrRxData;
  logic [1:0] evrRxCharIsK;
  logic [1:0] evrRxCharErr;
  logic [7:0] evrDistributedBus;
  logic [7:0] evrEventTDATA;
  logic evrEventTVALID;
  logic evrHeartbeatStrobe;
  logic evrHeartbeatTimeout;
  logic evrPPSstrobe;
  logic [TOD_SECONDS_WIDTH-1:0] evrSeconds;
  logic evrSecondsValid;
  logic evrLinkUp;
  logic [15:0] evrRxErrorCount;
  modport master (
    output evrRxData, evrRxCharIsK, evrRxCharErr,
    input evrDistributedBus, evrEventTDATA, evrEventTVALID, evrHeartbeatStrobe, evrHeartbeatTimeout,
    input evrPPSstrobe, evrSeconds, evrSecondsValid, evrLinkUp, evrRxErrorCount
  );
  modport slave (
    input evrRxData, evrRxCharIsK, evrRxCharErr,
    output evrDistributedBus, evrEventTDATA, evrEventTVALID, evrHeartbeatStrobe, evrHeartbeatTimeout,
    output evrPPSstrobe, evrSeconds, evrSecondsValid, evrLinkUp, evrRxErrorCount
  );
endinterface

// File: rtl/evr_rx_decoder.sv
// evr_rx_decoder: event receiver decoder (link status, events, heartbeat, PPS, serial TOD); EVR_RX_ERROR_COUNT_EN enables character error counting/suppression
module evr_rx_decoder #(
  parameter int RXCLK_NOMINAL_FREQUENCY = 125000000,
  parameter int TOD_SECONDS_WIDTH = 32,
  parameter int COMMA_TIMEOUT_CYCLES = 1024,
  parameter int HEARTBEAT_TIMEOUT_CYCLES = 2 * RXCLK_NOMINAL_FREQUENCY
) (
  input logic evrRxClk,
  input logic evrRxReset,
  evr_rx_decoder_if.slave rx
);
  localparam int W = TOD_SECONDS_WIDTH;
  localparam int CW = $clog2(COMMA_TIMEOUT_CYCLES) + 1;
  localparam int HW = $clog2(HEARTBEAT_TIMEOUT_CYCLES) + 1;
  localparam int BW = $clog2(TOD_SECONDS_WIDTH + 1) + 1;
  localparam logic [CW-1:0] COMMA_RELOAD = CW'(COMMA_TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HEARTBEAT_RELOAD = HW'(HEARTBEAT_TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BITS_FULL = BW'(W);
  localparam logic [BW-1:0] BITS_OVER = BW'(W + 1);

  logic [7:0] code;
  logic isK, decodeEn, isComma, isEvent, isShift, isMarker, isBeat;
  logic linkUp, heartbeatTimeout;
  logic [CW-1:0] commaTimer;
  logic [HW-1:0] heartbeatTimer;
  logic [W-1:0] shiftReg;
  logic [BW-1:0] bitCount;
  logic unusedBits;

  assign code = rx.evrRxData[7:0];
  assign isK = rx.evrRxCharIsK[0];
  assign rx.evrLinkUp = linkUp;
  assign rx.evrHeartbeatTimeout = heartbeatTimeout;

`ifdef EVR_RX_ERROR_COUNT_EN
  assign decodeEn = !rx.evrRxCharErr[0];
  assign unusedBits = rx.evrRxCharIsK[1];
`else
  assign decodeEn = 1'b1;
  assign unusedBits = ^{rx.evrRxCharIsK[1], rx.evrRxCharErr};
`endif

  // Classify the low byte; real events only exist while the link is up
  always_comb begin
    isComma = decodeEn && isK && code == 8'hBC;
    isEvent = decodeEn && linkUp && !isK && code != 8'h00;
    isShift = isEvent && code[7:1] == 7'h38;
    isMarker = isEvent && code == 8'h7D;
    isBeat = isEvent && code == 8'h7A;
  end

  // Comma watchdog: each K28.5 restarts the window, expiry drops the link
  always_ff @(posedge evrRxClk or posedge evrRxReset) begin
    if (evrRxReset) begin
      commaTimer <= '0;
      linkUp <= 1'b0;
    end else if (isComma) begin
      commaTimer <= COMMA_RELOAD;
      linkUp <= 1'b1;
    end else if (commaTimer == '0) begin
      linkUp <= 1'b0;
    end else begin
      commaTimer <= commaTimer - 1'b1;
    end
  end

  // Registered bus passthrough and one-cycle event strobes
  always_ff @(posedge evrRxClk or posedge evrRxReset) begin
    if (evrRxReset) begin
      rx.evrDistributedBus <= '0;
      rx.evrEventTDATA <= '0;
      rx.evrEventTVALID <= 1'b0;
      rx.evrHeartbeatStrobe <= 1'b0;
      rx.evrPPSstrobe <= 1'b0;
    end else begin
      rx.evrDistributedBus <= rx.evrRxData[15:8];
      rx.evrEventTDATA <= isEvent ? code : rx.evrEventTDATA;
      rx.evrEventTVALID <= isEvent;
      rx.evrHeartbeatStrobe <= isBeat;
      rx.evrPPSstrobe <= isMarker;
    end
  end

  // Heartbeat watchdog keeps counting even with the link down
  always_ff @(posedge evrRxClk or posedge evrRxReset) begin
    if (evrRxReset) begin
      heartbeatTimer <= '0;
      heartbeatTimeout <= 1'b1;
    end else if (isBeat) begin
      heartbeatTimer <= HEARTBEAT_RELOAD;
      heartbeatTimeout <= 1'b0;
    end else if (heartbeatTimer == '0) begin
      heartbeatTimeout <= 1'b1;
    end else begin
      heartbeatTimer <= heartbeatTimer - 1'b1;
    end
  end

  // Serial TOD: accept the shifted value only when exactly W bits preceded the marker
  always_ff @(posedge evrRxClk or posedge evrRxReset) begin
    if (evrRxReset) begin
      shiftReg <= '0;
      bitCount <= '0;
      rx.evrSeconds <= '0;
      rx.evrSecondsValid <= 1'b0;
    end else if (!linkUp) begin
      bitCount <= '0;
      rx.evrSecondsValid <= 1'b0;
    end else if (isShift) begin
      shiftReg <= {shiftReg[W-2:0], code[0]};
      bitCount <= (bitCount == BITS_OVER) ? bitCount : bitCount + 1'b1;
    end else if (isMarker) begin
      bitCount <= '0;
      rx.evrSeconds <= (bitCount == BITS_FULL) ? shiftReg : rx.evrSeconds;
      rx.evrSecondsValid <= bitCount == BITS_FULL;
    end
  end

`ifdef EVR_RX_ERROR_COUNT_EN
  // Saturating count of cycles that carry any character error
  always_ff @(posedge evrRxClk or posedge evrRxReset) begin
    if (evrRxReset)
      rx.evrRxErrorCount <= '0;
    else if (|rx.evrRxCharErr && rx.evrRxErrorCount != 16'hFFFF)
      rx.evrRxErrorCount <= rx.evrRxErrorCount + 16'd1;
  end
`else
  assign rx.evrRxErrorCount = '0;
`endif
endmodule

// File: tb/tb_evr_rx_decoder.sv
// tb_evr_rx_decoder: randomized + directed scoreboard bench against a history-based reference model
module tb_evr_rx_decoder;
  localparam int W = 32;
  localparam int C = 1024;
  localparam int H = 100;
`ifdef EVR_RX_ERROR_COUNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    int due;
    logic [7:0] bus;
    logic [7:0] tdata;
    logic tvalid;
    logic hb;
    logic hbTo;
    logic pps;
    logic [W-1:0] sec;
    logic secV;
    logic link;
    logic [15:0] errc;
  } exp_t;

  logic evrRxClk = 1'b0;
  logic evrRxReset = 1'b0;
  evr_rx_decoder_if #(.TOD_SECONDS_WIDTH(W)) rxIf ();
  evr_rx_decoder #(
    .TOD_SECONDS_WIDTH(W),
    .COMMA_TIMEOUT_CYCLES(C),
    .HEARTBEAT_TIMEOUT_CYCLES(H)
  ) dut (
    .evrRxClk(evrRxClk),
    .evrRxReset(evrRxReset),
    .rx(rxIf)
  );

  always #5 evrRxClk = ~evrRxClk;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  exp_t mon;
  exp_t m;
  int n, lastComma, lastBeat;
  bit haveComma, haveBeat;
  bit bits[$];

  always @(posedge evrRxClk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: dut=%0h expected=%0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic chkAll(input exp_t e);
    vectors++;
    chk("distributedBus", rxIf.evrDistributedBus, e.bus);
    chk("eventTVALID", rxIf.evrEventTVALID, e.tvalid);
    if (e.tvalid) chk("eventTDATA", rxIf.evrEventTDATA, e.tdata);
    chk("heartbeatStrobe", rxIf.evrHeartbeatStrobe, e.hb);
    chk("heartbeatTimeout", rxIf.evrHeartbeatTimeout, e.hbTo);
    chk("ppsStrobe", rxIf.evrPPSstrobe, e.pps);
    chk("seconds", rxIf.evrSeconds, e.sec);
    chk("secondsValid", rxIf.evrSecondsValid, e.secV);
    chk("linkUp", rxIf.evrLinkUp, e.link);
    chk("rxErrorCount", rxIf.evrRxErrorCount, e.errc);
  endtask

  // Monitor: every cycle the DUT presents a registered output word for the input one cycle earlier
  always @(negedge evrRxClk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon = q.pop_front();
      if (mon.due != cyc) begin
        miscompares++;
        $display("FAIL scoreboard: entry due %0d checked at %0d", mon.due, cyc);
      end
      chkAll(mon);
    end
  end

  task automatic modelReset();
    n = 0;
    haveComma = 0;
    haveBeat = 0;
    lastComma = 0;
    lastBeat = 0;
    bits.delete();
    m = '{due: 0, bus: 8'h00, tdata: 8'h00, tvalid: 1'b0, hb: 1'b0, hbTo: 1'b1, pps: 1'b0,
          sec: '0, secV: 1'b0, link: 1'b0, errc: 16'h0000};
  endtask

  // Drive one word (called just after a rising edge) and queue the expected response
  task automatic step(input logic [7:0] code, input bit k, input logic [7:0] bus, input logic [1:0] err);
    bit linkPrev, dec, ev;
    rxIf.evrRxData = {bus, code};
    rxIf.evrRxCharIsK = {1'($urandom), k};
    rxIf.evrRxCharErr = err;
    linkPrev = haveComma && (n - lastComma) < C;
    dec = !(ERR_EN && err[0]);
    ev = dec && linkPrev && !k && code != 8'h00;
    if (dec && k && code == 8'hBC) begin
      haveComma = 1;
      lastComma = n;
    end
    if (ev && code == 8'h7A) begin
      haveBeat = 1;
      lastBeat = n;
    end
    m.bus = bus;
    m.tvalid = ev;
    if (ev) m.tdata = code;
    m.hb = ev && code == 8'h7A;
    m.pps = ev && code == 8'h7D;
    m.link = haveComma && (n - lastComma) < C;
    m.hbTo = !haveBeat || (n - lastBeat) >= H;
    if (!linkPrev) begin
      bits.delete();
      m.secV = 0;
    end else if (ev && (code == 8'h70 || code == 8'h71)) begin
      bits.push_back(code[0]);
      if (bits.size() > W + 1) void'(bits.pop_front());
    end else if (m.pps) begin
      if (bits.size() == W) begin
        foreach (bits[i]) m.sec = {m.sec[W-2:0], bits[i]};
        m.secV = 1;
      end else begin
        m.secV = 0;
      end
      bits.delete();
    end
    if (ERR_EN && err != 2'b00 && m.errc != 16'hFFFF) m.errc++;
    n++;
    m.due = cyc + 1;
    q.push_back(m);
    @(posedge evrRxClk);
    #1;
  endtask

  task automatic doReset();
    rxIf.evrRxData = '0;
    rxIf.evrRxCharIsK = '0;
    rxIf.evrRxCharErr = '0;
    evrRxReset = 1'b1;
    q.delete();
    modelReset();
    #2;
    chkAll(m);
    #1 evrRxReset = 1'b0;
  endtask

  task automatic idle(input int cnt);
    repeat (cnt) step(8'h00, 0, 8'($urandom), 2'b00);
  endtask

  task automatic comma();
    step(8'hBC, 1, 8'($urandom), 2'b00);
  endtask

  task automatic marker();
    step(8'h7D, 0, 8'($urandom), 2'b00);
  endtask

  task automatic sendBits(input logic [63:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) step(v[i] ? 8'h71 : 8'h70, 0, 8'($urandom), 2'b00);
  endtask

  initial begin
    rxIf.evrRxData = '0;
    rxIf.evrRxCharIsK = '0;
    rxIf.evrRxCharErr = '0;
    modelReset();
    @(posedge evrRxClk);
    #1;
    doReset();
    repeat (6) begin
      comma();
      idle(3);
    end
    step(8'h2A, 0, 8'hA5, 2'b00);
    step(8'h00, 0, 8'h5A, 2'b00);
    comma();
    step(8'h1C, 1, 8'h33, 2'b00);
    step(8'h7A, 0, 8'h01, 2'b00);
    comma();
    sendBits(64'h12345678, 32);
    marker();
    idle(2);
    sendBits(64'($urandom), 31);
    marker();
    sendBits({32'h1, 32'($urandom)}, 33);
    marker();
    comma();
    step(8'h7A, 0, 8'h00, 2'b00);
    idle(110);
    comma();
    idle(C + 5);
    step(8'h7A, 0, 8'h00, 2'b00);
    step(8'h71, 0, 8'h00, 2'b00);
    step(8'h7D, 0, 8'h00, 2'b00);
    comma();
    sendBits(64'h3FF, 10);
    doReset();
    comma();
    sendBits(64'h15, 5);
    marker();
    comma();
    sendBits(64'hCAFEF00D, 32);
    marker();
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] e;
      logic [7:0] b;
      r = $urandom_range(0, 15);
      e = ($urandom_range(0, 19) == 0) ? 2'($urandom) : 2'b00;
      b = 8'($urandom);
      if (r < 2) step(8'hBC, 1, b, e);
      else if (r < 8) step(r[0] ? 8'h71 : 8'h70, 0, b, e);
      else if (r == 8) step(8'h7D, 0, b, e);
      else if (r == 9) step(8'h7A, 0, b, e);
      else if (r == 10) step(8'h00, 0, b, e);
      else step(8'($urandom), $urandom_range(0, 3) == 0, b, e);
    end
`ifdef EVR_RX_ERROR_COUNT_EN
    doReset();
    comma();
    sendBits(64'hA5A5, 16);
    step(8'h71, 0, 8'h00, 2'b01);
    step(8'h00, 0, 8'h00, 2'b01);
    step(8'hBC, 1, 8'h00, 2'b01);
    sendBits(64'h5A5A, 16);
    marker();
    for (int i = 0; i < 70000; i++) step(8'($urandom), 1'($urandom), 8'($urandom), 2'($urandom_range(1, 3)));
`endif
    idle(3);
    repeat (2) @(posedge evrRxClk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
